bus_mm_rr: RTL

//  Shared system bus for NUM_MASTERS masters (cache, DMA, debug) and one slave (memory controller).

---
 rtl/bus_mm_rr_if.sv | 40 ++++
 rtl/bus_mm_rr.sv | 118 +++++++++++
 2 files changed

// File: rtl/bus_mm_rr_if.sv
// Signal bundle for the multi-master shared bus: packed per-master request side plus the single slave side.
// Modports: master (the masters), slave (memory controller), ctrl (arbiter/mux in between).
interface bus_mm_rr_if #(
    parameter int NUM_MASTERS    = 2,
    parameter int BUS_ADR_WIDTH  = 14,
    parameter int BUS_DATA_WIDTH = 64
);
    logic [NUM_MASTERS*BUS_ADR_WIDTH-1:0]  m_bus_address;
    logic [NUM_MASTERS*BUS_DATA_WIDTH-1:0] m_bus_dataout;
    logic [BUS_DATA_WIDTH-1:0]             m_bus_datain;
    logic [NUM_MASTERS-1:0]                m_bus_rd;
    logic [NUM_MASTERS-1:0]                m_bus_wr;
    logic [NUM_MASTERS-1:0]                m_bus_req;
    logic [NUM_MASTERS-1:0]                m_bus_gnt;
    logic [NUM_MASTERS-1:0]                m_bus_ready;
    logic [NUM_MASTERS-1:0]                m_bus_err;
    logic [BUS_ADR_WIDTH-1:0]              s_bus_address;
    logic [BUS_DATA_WIDTH-1:0]             s_bus_datain;
    logic [BUS_DATA_WIDTH-1:0]             s_bus_dataout;
    logic                                  s_bus_rd;
    logic                                  s_bus_wr;
    logic                                  s_bus_ready;

    modport master (
        output m_bus_address, m_bus_dataout, m_bus_rd, m_bus_wr, m_bus_req,
        input  m_bus_datain, m_bus_gnt, m_bus_ready, m_bus_err
    );

    modport slave (
        input  s_bus_address, s_bus_datain, s_bus_rd, s_bus_wr,
        output s_bus_dataout, s_bus_ready
    );

    modport ctrl (
        input  m_bus_address, m_bus_dataout, m_bus_rd, m_bus_wr, m_bus_req,
        output m_bus_datain, m_bus_gnt, m_bus_ready, m_bus_err,
        output s_bus_address, s_bus_datain, s_bus_rd, s_bus_wr,
        input  s_bus_dataout, s_bus_ready
    );
endinterface

// File: rtl/bus_mm_rr.sv
// Round-robin arbitrated shared bus: N masters to one slave; owner's address/data/strobes muxed to the slave.
// Latency: grant 1 cycle after req, one idle turnaround between tenures; data path is combinational.
// Backpressure: owner holds rd/wr until ready; optional BUS_TIMEOUT_EN watchdog ends a hung transfer with err.
module bus_mm_rr #(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_ADR_WIDTH  = 14,
    parameter int NUM_MASTERS    = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input logic         clk,
    input logic         rst,
    bus_mm_rr_if.ctrl   bus
);
    localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT_CYCLES);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t                 state_q, state_d;
    logic [IW-1:0]          owner_q, owner_d;
    logic [IW-1:0]          rr_ptr_q, rr_ptr_d;
    logic [NUM_MASTERS-1:0] gnt_q, gnt_d;
    logic [IW-1:0]          sel;
    logic                   sel_found;

    logic [BUS_ADR_WIDTH-1:0]  own_adr;
    logic [BUS_DATA_WIDTH-1:0] own_dat;
    logic                      own_rd, own_wr, own_req, own_pend, busy, timeout;

    assign busy     = (state_q == BUSY);
    assign own_adr  = bus.m_bus_address[int'(owner_q)*BUS_ADR_WIDTH +: BUS_ADR_WIDTH];
    assign own_dat  = bus.m_bus_dataout[int'(owner_q)*BUS_DATA_WIDTH +: BUS_DATA_WIDTH];
    assign own_rd   = bus.m_bus_rd[owner_q];
    assign own_wr   = bus.m_bus_wr[owner_q];
    assign own_req  = bus.m_bus_req[owner_q];
    assign own_pend = own_rd | own_wr;

    // Scan from the highest offset down so the last hit is the first requester after rr_ptr.
    always_comb begin
        logic [IW-1:0] cand;
        sel       = '0;
        sel_found = 1'b0;
        cand      = '0;
        for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
            cand = IW'((int'(rr_ptr_q) + k) % NUM_MASTERS);
            if (bus.m_bus_req[cand]) begin
                sel       = cand;
                sel_found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        gnt_d    = gnt_q;
        case (state_q)
            IDLE: begin
                if (sel_found) begin
                    state_d = BUSY;
                    owner_d = sel;
                    for (int i = 0; i < NUM_MASTERS; i++) gnt_d[i] = (sel == IW'(i));
                end
            end
            BUSY: begin
                if (!own_req && !own_pend) begin
                    state_d  = IDLE;
                    gnt_d    = '0;
                    rr_ptr_d = (owner_q == IW'(NUM_MASTERS - 1)) ? '0 : owner_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            owner_q  <= '0;
            rr_ptr_q <= '0;
            gnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            gnt_q    <= gnt_d;
        end
    end

`ifdef BUS_TIMEOUT_EN
    logic [7:0] to_cnt_q;
    logic       stall;

    assign stall   = busy & own_pend & ~bus.s_bus_ready;
    assign timeout = stall & (to_cnt_q == TO_LIMIT);

    always_ff @(posedge clk) begin
        if (!rst || !stall || timeout) to_cnt_q <= '0;
        else                           to_cnt_q <= to_cnt_q + 8'd1;
    end
`else
    // Limit is irrelevant here; folding it in keeps the parameter referenced.
    assign timeout = 1'b0 & (TO_LIMIT == 8'd0);
`endif

    assign bus.s_bus_address = busy ? own_adr : '0;
    assign bus.s_bus_datain  = busy ? own_dat : '0;
    assign bus.s_bus_wr      = busy & own_wr & ~timeout;
    assign bus.s_bus_rd      = busy & own_rd & ~own_wr & ~timeout;
    assign bus.m_bus_datain  = timeout ? '1 : bus.s_bus_dataout;
    assign bus.m_bus_gnt     = gnt_q;
    assign bus.m_bus_ready   = gnt_q & {NUM_MASTERS{bus.s_bus_ready | timeout}};
    assign bus.m_bus_err     = gnt_q & {NUM_MASTERS{timeout}};
endmodule
